// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS control unit. A two-process state machine steps each
// instruction through fetch, decode, execute, memory and write-back against a
// single shared instruction/data memory that can insert wait states through
// mem_ready. All control outputs are decoded from the current state. The only
// exceptions are the FETCH load strobes, the MEMWR completion pulse and the
// branch PC write, which also follow mem_ready or zero in the same cycle.
//
// Parameters
//   ENABLE_ADDI     : 1 decodes opcode 001000 (addi), 0 treats it as illegal
//   ENABLE_BNE      : 1 decodes opcode 000101 (bne),  0 treats it as illegal
//   HALT_ON_ILLEGAL : 1 parks in HALT on an illegal instruction,
//                     0 retires it as a NOP and fetches the next one
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   op, funct           : instruction fields from the instruction register
//   zero                : ALU zero flag (branch condition)
//   mem_ready           : memory completes the current access this cycle
//   mem_req, mem_we     : memory request and write qualifier
//   iord                : memory address select (0 PC, 1 ALU-out)
//   ir_write, pc_write  : instruction register and PC load enables
//   pc_src              : PC source (00 ALU, 01 ALU-out, 10 jump target)
//   alu_src_a/b, alu_ctrl : ALU operand selects and operation
//   reg_dst, mem_to_reg, reg_write : register-file write controls
//   instr_done          : pulse in the last cycle of every instruction
//   illegal             : sticky illegal-instruction flag
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter bit ENABLE_ADDI     = 1'b1,
    parameter bit ENABLE_BNE      = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       illegal_hit_s;

    logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
    logic [1:0] pc_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_ctrl_s;
    logic       reg_dst_s, mem_to_reg_s, reg_write_s, instr_done_s;

    // State register and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control decode for the current state.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        illegal_hit_s = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        iord_s        = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_src_s      = 2'b00;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        alu_ctrl_s    = ALU_AND;
        reg_dst_s     = 1'b0;
        mem_to_reg_s  = 1'b0;
        reg_write_s   = 1'b0;
        instr_done_s  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read; both the
                // IR and the PC load only on the cycle the memory completes.
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                alu_ctrl_s  = ALU_ADD;
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALU-out.
                alu_src_b_s = 2'b11;
                alu_ctrl_s  = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (ENABLE_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            illegal_hit_s = 1'b1;
                        end
                    end
                    OP_ADDI: begin
                        if (ENABLE_ADDI) begin
                            state_d = S_ADDIEX;
                        end else begin
                            illegal_hit_s = 1'b1;
                        end
                    end
                    default: illegal_hit_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_ctrl_s  = ALU_ADD;
                // Only lw and sw reach this state, so one compare suffices.
                if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    instr_done_s = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                state_d     = S_ALUWB;
                case (funct)
                    FN_ADD:  alu_ctrl_s = ALU_ADD;
                    FN_SUB:  alu_ctrl_s = ALU_SUB;
                    FN_AND:  alu_ctrl_s = ALU_AND;
                    FN_OR:   alu_ctrl_s = ALU_OR;
                    FN_SLT:  alu_ctrl_s = ALU_SLT;
                    default: illegal_hit_s = 1'b1;
                endcase
            end
            S_ALUWB: begin
                reg_dst_s    = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_ctrl_s   = ALU_SUB;
                pc_src_s     = 2'b01;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
                if (ENABLE_BNE && (op == OP_BNE)) begin
                    pc_write_s = ~zero;
                end else begin
                    pc_write_s = zero;
                end
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_ctrl_s  = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_s     = 2'b10;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unused encodings recover to a fresh fetch.
                state_d = S_FETCH;
            end
        endcase

        // Illegal opcodes and functs share one resolution path: the flag is
        // latched, then either park in HALT or retire as a NOP with no writes.
        if (illegal_hit_s) begin
            illegal_d = 1'b1;
            if (HALT_ON_ILLEGAL) begin
                state_d = S_HALT;
            end else begin
                state_d      = S_FETCH;
                instr_done_s = 1'b1;
            end
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Output stage: reset holds every output low in the cycle it is asserted,
    // so an aborted store never reaches memory.
    always_comb begin
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctrl   = 3'b000;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end else begin
            mem_req    = mem_req_s;
            mem_we     = mem_we_s;
            iord       = iord_s;
            ir_write   = ir_write_s;
            pc_write   = pc_write_s;
            pc_src     = pc_src_s;
            alu_src_a  = alu_src_a_s;
            alu_src_b  = alu_src_b_s;
            alu_ctrl   = alu_ctrl_s;
            reg_dst    = reg_dst_s;
            mem_to_reg = mem_to_reg_s;
            reg_write  = reg_write_s;
            instr_done = instr_done_s;
            illegal    = illegal_q;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Two controller instances: dut0 decodes everything and halts on illegal
// instructions; dut1 has addi/bne disabled and retires illegal ones as NOPs.
// Each instruction is expanded into the list of control words it should
// produce, cycle by cycle, from the instruction-level description. The list
// is walked with random wait states, random zero flags and random mem_ready
// outside memory cycles. Each instruction's latency to instr_done is also
// checked against the documented cycle counts.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [2];
    logic [5:0]  op_v    [2];
    logic [5:0]  funct_v [2];
    logic        zero_v  [2];
    logic        rdy_v   [2];
    logic [17:0] obs     [2];
    bit          ill_m   [2];

    int checks   = 0;
    int failures = 0;

    // Control word layout:
    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src[1:0], alu_src_a,
    //  alu_src_b[1:0], alu_ctrl[2:0], reg_dst, mem_to_reg, reg_write,
    //  instr_done, illegal}
    localparam logic [17:0] B_REQ    = 18'd1 << 17;
    localparam logic [17:0] B_WE     = 18'd1 << 16;
    localparam logic [17:0] B_IORD   = 18'd1 << 15;
    localparam logic [17:0] B_IRW    = 18'd1 << 14;
    localparam logic [17:0] B_PCW    = 18'd1 << 13;
    localparam logic [17:0] B_PCS_01 = 18'd1 << 11;
    localparam logic [17:0] B_PCS_10 = 18'd2 << 11;
    localparam logic [17:0] B_ASA    = 18'd1 << 10;
    localparam logic [17:0] B_ASB_01 = 18'd1 << 8;
    localparam logic [17:0] B_ASB_10 = 18'd2 << 8;
    localparam logic [17:0] B_ASB_11 = 18'd3 << 8;
    localparam logic [17:0] A_AND    = 18'd0;
    localparam logic [17:0] A_OR     = 18'd1 << 5;
    localparam logic [17:0] A_ADD    = 18'd2 << 5;
    localparam logic [17:0] A_SUB    = 18'd6 << 5;
    localparam logic [17:0] A_SLT    = 18'd7 << 5;
    localparam logic [17:0] B_RD     = 18'd1 << 4;
    localparam logic [17:0] B_M2R    = 18'd1 << 3;
    localparam logic [17:0] B_RW     = 18'd1 << 2;
    localparam logic [17:0] B_DONE   = 18'd1 << 1;
    localparam logic [17:0] B_ILL    = 18'd1;
    localparam logic [17:0] NONE     = 18'd0;

    localparam logic [17:0] W_FETCH  = B_REQ | B_ASB_01 | A_ADD;
    localparam logic [17:0] W_DECODE = B_ASB_11 | A_ADD;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [17:0] word;
        logic [17:0] rdy_m;
        logic [17:0] z_m;
        logic [17:0] nz_m;
        logic        mem;
        logic        set_ill;
    } step_t;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
        logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;
        logic [1:0] pc_src, alu_src_b;
        logic [2:0] alu_ctrl;

        mc_controller #(
            .ENABLE_ADDI     (g == 0),
            .ENABLE_BNE      (g == 0),
            .HALT_ON_ILLEGAL (g == 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .op         (op_v[g]),
            .funct      (funct_v[g]),
            .zero       (zero_v[g]),
            .mem_ready  (rdy_v[g]),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .iord       (iord),
            .ir_write   (ir_write),
            .pc_write   (pc_write),
            .pc_src     (pc_src),
            .alu_src_a  (alu_src_a),
            .alu_src_b  (alu_src_b),
            .alu_ctrl   (alu_ctrl),
            .reg_dst    (reg_dst),
            .mem_to_reg (mem_to_reg),
            .reg_write  (reg_write),
            .instr_done (instr_done),
            .illegal    (illegal)
        );

        assign obs[g] = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                         alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
                         reg_write, instr_done, illegal};
    end

    function automatic step_t mk(input logic [17:0] word, input logic [17:0] rdy_m,
                                 input logic [17:0] z_m, input logic [17:0] nz_m,
                                 input logic mem, input logic set_ill);
        step_t s;
        s.word    = word;
        s.rdy_m   = rdy_m;
        s.z_m     = z_m;
        s.nz_m    = nz_m;
        s.mem     = mem;
        s.set_ill = set_ill;
        return s;
    endfunction

    // Tasks start and end just after a falling edge.
    task automatic do_reset(input int g);
        rst_v[g] = 1'b1;
        rdy_v[g] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_v[g] = 1'b0;
        ill_m[g] = 1'b0;
    endtask

    // Run one instruction on dut g. fw/dw are wait states in fetch/data
    // access (-1 random), zmode 0/1 fixes zero, 2 randomises it.
    task automatic run_instr(input string tag, input int g, input logic [5:0] o,
                             input logic [5:0] f, input int fw, input int dw,
                             input int zmode, output bit halted);
        step_t       steps[$];
        bit          en       = (g == 0);
        bit          halt_pol = (g == 0);
        bit          dec_ill;
        bit          fn_ok    = 1'b1;
        logic [17:0] alu      = A_AND;
        int          base     = 0;
        int          waits    = 0;
        int          cyc      = 0;
        int          done_at  = -1;
        halted     = 1'b0;
        op_v[g]    = o;
        funct_v[g] = f;

        steps.push_back(mk(W_FETCH, B_IRW | B_PCW, NONE, NONE, 1'b1, 1'b0));
        dec_ill = !((o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) ||
                    (o == OP_J) || ((o == OP_BNE) && en) || ((o == OP_ADDI) && en));
        if (dec_ill) begin
            steps.push_back(mk(W_DECODE | (halt_pol ? NONE : B_DONE), NONE, NONE, NONE, 1'b0, 1'b1));
            base   = halt_pol ? 0 : 2;
            halted = halt_pol;
        end else begin
            steps.push_back(mk(W_DECODE, NONE, NONE, NONE, 1'b0, 1'b0));
            case (o)
                OP_LW: begin
                    steps.push_back(mk(B_ASA | B_ASB_10 | A_ADD, NONE, NONE, NONE, 1'b0, 1'b0));
                    steps.push_back(mk(B_REQ | B_IORD, NONE, NONE, NONE, 1'b1, 1'b0));
                    steps.push_back(mk(B_M2R | B_RW | B_DONE, NONE, NONE, NONE, 1'b0, 1'b0));
                    base = 5;
                end
                OP_SW: begin
                    steps.push_back(mk(B_ASA | B_ASB_10 | A_ADD, NONE, NONE, NONE, 1'b0, 1'b0));
                    steps.push_back(mk(B_REQ | B_WE | B_IORD, B_DONE, NONE, NONE, 1'b1, 1'b0));
                    base = 4;
                end
                OP_R: begin
                    case (f)
                        6'b100000: alu = A_ADD;
                        6'b100010: alu = A_SUB;
                        6'b100100: alu = A_AND;
                        6'b100101: alu = A_OR;
                        6'b101010: alu = A_SLT;
                        default:   fn_ok = 1'b0;
                    endcase
                    if (fn_ok) begin
                        steps.push_back(mk(B_ASA | alu, NONE, NONE, NONE, 1'b0, 1'b0));
                        steps.push_back(mk(B_RD | B_RW | B_DONE, NONE, NONE, NONE, 1'b0, 1'b0));
                        base = 4;
                    end else begin
                        steps.push_back(mk(B_ASA | (halt_pol ? NONE : B_DONE), NONE, NONE, NONE, 1'b0, 1'b1));
                        base   = halt_pol ? 0 : 3;
                        halted = halt_pol;
                    end
                end
                OP_BEQ: begin
                    steps.push_back(mk(B_ASA | A_SUB | B_PCS_01 | B_DONE, NONE, B_PCW, NONE, 1'b0, 1'b0));
                    base = 3;
                end
                OP_BNE: begin
                    steps.push_back(mk(B_ASA | A_SUB | B_PCS_01 | B_DONE, NONE, NONE, B_PCW, 1'b0, 1'b0));
                    base = 3;
                end
                OP_ADDI: begin
                    steps.push_back(mk(B_ASA | B_ASB_10 | A_ADD, NONE, NONE, NONE, 1'b0, 1'b0));
                    steps.push_back(mk(B_RW | B_DONE, NONE, NONE, NONE, 1'b0, 1'b0));
                    base = 4;
                end
                default: begin
                    steps.push_back(mk(B_PCS_10 | B_PCW | B_DONE, NONE, NONE, NONE, 1'b0, 1'b0));
                    base = 3;
                end
            endcase
        end

        foreach (steps[i]) begin : walk
            int w = 0;
            if (steps[i].mem) begin
                w = (i == 0) ? fw : dw;
                if (w < 0) w = int'($urandom_range(0, 3));
            end
            waits += w;
            for (int k = 0; k <= w; k++) begin : cycle
                logic        rdy;
                logic        zz;
                logic [17:0] exp;
                rdy = steps[i].mem ? (k == w) : 1'($urandom_range(0, 1));
                zz  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
                rdy_v[g]  = rdy;
                zero_v[g] = zz;
                #1;
                exp = steps[i].word
                    | ((steps[i].mem && rdy) ? steps[i].rdy_m : NONE)
                    | (zz ? steps[i].z_m : steps[i].nz_m)
                    | {17'd0, ill_m[g]};
                cyc++;
                checks++;
                if (obs[g] !== exp) begin
                    failures++;
                    $display("FAIL %s dut%0d op=%b funct=%b cycle=%0d got=%b expected=%b",
                             tag, g, o, f, cyc, obs[g], exp);
                end
                if ((obs[g][1] === 1'b1) && (done_at < 0)) done_at = cyc;
                @(negedge clk);
            end
            if (steps[i].set_ill) ill_m[g] = 1'b1;
        end

        checks++;
        if (done_at != ((base > 0) ? (base + waits) : -1)) begin
            failures++;
            $display("FAIL %s_latency dut%0d op=%b funct=%b got=%0d expected=%0d",
                     tag, g, o, f, done_at, (base > 0) ? (base + waits) : -1);
        end
    endtask

    task automatic check_halt(input int g, input int n);
        for (int c = 0; c < n; c++) begin
            rdy_v[g]  = 1'($urandom_range(0, 1));
            zero_v[g] = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs[g] !== B_ILL) begin
                failures++;
                $display("FAIL halt dut%0d cycle=%0d got=%b expected=%b", g, c, obs[g], B_ILL);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            rst_v[g] = 1'b1;
            rdy_v[g] = 1'b1;
            zero_v[g] = 1'b1;
            op_v[g] = OP_LW;
            funct_v[g] = 6'b100000;
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (obs[g] !== NONE) begin
                    failures++;
                    $display("FAIL reset_hold dut%0d got=%b expected=%b", g, obs[g], NONE);
                end
            end
            @(negedge clk);
        end
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs[g] !== (W_FETCH | B_IRW | B_PCW)) begin
                failures++;
                $display("FAIL reset_release dut%0d got=%b expected=%b", g, obs[g], W_FETCH | B_IRW | B_PCW);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lw();
        bit h;
        do_reset(0);
        run_instr("lw_nowait", 0, OP_LW, 6'b000000, 0, 0, 2, h);
        run_instr("lw_wait", 0, OP_LW, 6'b000000, -1, -1, 2, h);
        do_reset(1);
        run_instr("lw_wait", 1, OP_LW, 6'b000000, -1, -1, 2, h);
    endtask

    task automatic test_sw_wait();
        bit h;
        do_reset(0);
        run_instr("sw_3wait", 0, OP_SW, 6'b000000, 0, 3, 2, h);
        run_instr("sw_rand", 0, OP_SW, 6'b000000, -1, -1, 2, h);
    endtask

    task automatic test_branch();
        bit h;
        do_reset(0);
        run_instr("beq_z1", 0, OP_BEQ, 6'b000000, 0, 0, 1, h);
        run_instr("beq_z0", 0, OP_BEQ, 6'b000000, 0, 0, 0, h);
        run_instr("bne_z1", 0, OP_BNE, 6'b000000, 0, 0, 1, h);
        run_instr("bne_z0", 0, OP_BNE, 6'b000000, -1, 0, 0, h);
        do_reset(1);
        run_instr("bne_disabled", 1, OP_BNE, 6'b000000, 0, 0, 1, h);
        run_instr("after_bne", 1, OP_BEQ, 6'b000000, 0, 0, 1, h);
    endtask

    task automatic test_rtype();
        bit h;
        logic [5:0] fns [5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        do_reset(0);
        foreach (fns[i]) run_instr("rtype", 0, OP_R, fns[i], -1, 0, 2, h);
    endtask

    task automatic test_addi_jump();
        bit h;
        do_reset(0);
        run_instr("addi", 0, OP_ADDI, 6'b000000, 0, 0, 2, h);
        run_instr("jump", 0, OP_J, 6'b000000, -1, 0, 2, h);
        do_reset(1);
        run_instr("addi_disabled", 1, OP_ADDI, 6'b000000, 0, 0, 2, h);
        run_instr("jump", 1, OP_J, 6'b000000, 0, 0, 2, h);
    endtask

    task automatic test_halt();
        bit h;
        do_reset(0);
        run_instr("bad_funct", 0, OP_R, 6'b000000, 0, 0, 2, h);
        check_halt(0, 10);
        do_reset(0);
        run_instr("after_halt", 0, OP_LW, 6'b000000, 0, 0, 2, h);
    endtask

    task automatic test_illegal_nop();
        bit h;
        do_reset(1);
        run_instr("bad_op", 1, OP_BAD, 6'b000000, 0, 0, 2, h);
        run_instr("add_after_bad", 1, OP_R, 6'b100000, 0, 0, 2, h);
        run_instr("bad_funct_nop", 1, OP_R, 6'b000111, 0, 0, 2, h);
        run_instr("sw_after_bad", 1, OP_SW, 6'b000000, 0, 1, 2, h);
    endtask

    task automatic test_reset_abort();
        do_reset(0);
        op_v[0] = OP_SW;
        for (int c = 0; c < 3; c++) begin
            rdy_v[0] = 1'b1;
            #1;
            @(negedge clk);
        end
        rdy_v[0] = 1'b0;
        #1;
        checks++;
        if (obs[0] !== (B_REQ | B_WE | B_IORD)) begin
            failures++;
            $display("FAIL abort_memwr got=%b expected=%b", obs[0], B_REQ | B_WE | B_IORD);
        end
        @(negedge clk);
        rst_v[0] = 1'b1;
        rdy_v[0] = 1'b1;
        #1;
        checks++;
        if (obs[0] !== NONE) begin
            failures++;
            $display("FAIL abort_rst got=%b expected=%b", obs[0], NONE);
        end
        @(negedge clk);
        rst_v[0] = 1'b0;
        ill_m[0] = 1'b0;
        #1;
        checks++;
        if (obs[0] !== (W_FETCH | B_IRW | B_PCW)) begin
            failures++;
            $display("FAIL abort_refetch got=%b expected=%b", obs[0], W_FETCH | B_IRW | B_PCW);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit h;
        logic [5:0] ops [9] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_R, OP_BAD};
        logic [5:0] fns [5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        for (int g = 0; g < 2; g++) begin
            do_reset(g);
            for (int n = 0; n < 25; n++) begin
                logic [5:0] o;
                logic [5:0] f;
                o = ops[$urandom_range(0, 8)];
                if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
                f = fns[$urandom_range(0, 4)];
                if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
                run_instr("b2b", g, o, f, -1, -1, 2, h);
                if (h) begin
                    check_halt(g, 3);
                    do_reset(g);
                end
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_v[g]   = 1'b1;
            op_v[g]    = 6'b000000;
            funct_v[g] = 6'b000000;
            zero_v[g]  = 1'b0;
            rdy_v[g]   = 1'b0;
            ill_m[g]   = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_rtype();
        test_addi_jump();
        test_halt();
        test_illegal_nop();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
